// File: rtl/alu_sequencer_if.sv
// Handshake and ALU-facing bundle for the ALU sequencer.
// The slave side is the sequencer itself.
// The master side is everything around it: the instruction source, the
// result consumer, the ALU and the debug reader.
interface alu_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 2
);

  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_op;
  logic [REG_AW-1:0] in_rd;
  logic [REG_AW-1:0] in_rs;
  logic              in_use_imm;
  logic [DATA_W-1:0] in_imm;

  logic [DATA_W-1:0] alu_a1;
  logic [DATA_W-1:0] alu_a2;
  logic [7:0]        alu_op_flag;
  logic              alu_e_flag;
  logic              alu_cin;
  logic [DATA_W-1:0] alu_out;
  logic              alu_cout;

  logic              done_valid;
  logic              done_ready;
  logic [DATA_W-1:0] done_result;
  logic              done_carry;

  logic [REG_AW-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;

  modport master (
    output in_valid, in_op, in_rd, in_rs, in_use_imm, in_imm,
    output alu_out, alu_cout,
    output done_ready,
    output dbg_addr,
    input  in_ready,
    input  alu_a1, alu_a2, alu_op_flag, alu_e_flag, alu_cin,
    input  done_valid, done_result, done_carry,
    input  dbg_data
  );

  modport slave (
    input  in_valid, in_op, in_rd, in_rs, in_use_imm, in_imm,
    input  alu_out, alu_cout,
    input  done_ready,
    input  dbg_addr,
    output in_ready,
    output alu_a1, alu_a2, alu_op_flag, alu_e_flag, alu_cin,
    output done_valid, done_result, done_carry,
    output dbg_data
  );

endinterface

// File: rtl/alu_sequencer.sv
// Control stage in front of the 8-bit ALU.
// It accepts one instruction at a time and reads both operands from a small
// register file. It then presents registered operands and a one-hot opcode
// to the ALU, captures the ALU result, writes it back, and offers it on the
// done handshake. Only one instruction is in flight at any time.
module alu_sequencer #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 2
) (
  input logic           clk,
  input logic           rst_n,
  alu_sequencer_if.slave bus
);

  localparam int NUM_REGS = 1 << REG_AW;

  localparam logic [2:0] OP_NOT = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_ADD = 3'd3;
  localparam logic [2:0] OP_SUB = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_ADC = 3'd6;
  localparam logic [2:0] OP_SBC = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    EXEC,
    DONE
  } state_t;

  state_t            state;
  state_t            state_next;

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              carry;
  logic [2:0]        op_q;
  logic [REG_AW-1:0] rd_q;

  logic              accept;
  logic [DATA_W-1:0] src_operand;

  // ADC and SBC reuse the ADD and SUB lanes of the ALU.
  // They differ from ADD and SUB only in the carry-in.
  function automatic logic [7:0] op_onehot(input logic [2:0] op);
    logic [7:0] flag;
    flag = 8'h00;
    case (op)
      OP_NOT: flag = 8'h01;
      OP_OR:  flag = 8'h02;
      OP_AND: flag = 8'h04;
      OP_ADD: flag = 8'h08;
      OP_SUB: flag = 8'h10;
      OP_XOR: flag = 8'h20;
      OP_ADC: flag = 8'h08;
      OP_SBC: flag = 8'h10;
      default: flag = 8'h00;
    endcase
    return flag;
  endfunction

  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADC) || (op == OP_SBC);
  endfunction

  function automatic logic uses_carry_in(input logic [2:0] op);
    return (op == OP_ADC) || (op == OP_SBC);
  endfunction

  assign bus.in_ready = (state == IDLE);
  assign accept       = bus.in_valid && (state == IDLE);
  assign src_operand  = bus.in_use_imm ? bus.in_imm : regs[bus.in_rs];
  assign bus.dbg_data = regs[bus.dbg_addr];

  // State register; reset drops any instruction in flight back to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Walk IDLE -> LOAD -> EXEC -> DONE; only IDLE and DONE wait on a handshake.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (bus.in_valid) state_next = LOAD;
      LOAD: state_next = EXEC;
      EXEC: state_next = DONE;
      DONE: if (bus.done_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Registered datapath: operand capture, ALU strobe, writeback and result hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      carry           <= 1'b0;
      op_q            <= '0;
      rd_q            <= '0;
      bus.alu_a1      <= '0;
      bus.alu_a2      <= '0;
      bus.alu_op_flag <= '0;
      bus.alu_e_flag  <= 1'b0;
      bus.alu_cin     <= 1'b0;
      bus.done_valid  <= 1'b0;
      bus.done_result <= '0;
      bus.done_carry  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q            <= bus.in_op;
            rd_q            <= bus.in_rd;
            bus.alu_a1      <= regs[bus.in_rd];
            bus.alu_a2      <= src_operand;
            bus.alu_op_flag <= op_onehot(bus.in_op);
            bus.alu_cin     <= uses_carry_in(bus.in_op) ? carry : 1'b0;
          end
        end
        LOAD: begin
          bus.alu_e_flag <= 1'b1;
        end
        EXEC: begin
          regs[rd_q]      <= bus.alu_out;
          bus.done_result <= bus.alu_out;
          if (is_arith(op_q)) begin
            carry          <= bus.alu_cout;
            bus.done_carry <= bus.alu_cout;
          end else begin
            bus.done_carry <= carry;
          end
          bus.alu_e_flag <= 1'b0;
          bus.done_valid <= 1'b1;
        end
        DONE: begin
          if (bus.done_ready) begin
            bus.done_valid <= 1'b0;
          end
        end
        default: begin
          bus.alu_e_flag <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer.
// A behavioural ALU answers the sequencer's strobes.
// Directed vectors cover the documented scenarios, followed by a stall
// scenario, a mid-operation reset, and randomized instructions.
// The randomized instructions are scored against an arithmetic model.
module tb_alu_sequencer;

  logic clk;
  logic rst_n;

  alu_sequencer_if #(.DATA_W(8), .REG_AW(2)) bus ();

  alu_sequencer #(.DATA_W(8), .REG_AW(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int checks;
  int failures;

  logic [7:0] ref_regs [4];
  logic       ref_carry;

  typedef struct {
    logic [2:0] op;
    logic [1:0] rd;
    logic [1:0] rs;
    logic       use_imm;
    logic [7:0] imm;
    logic [7:0] res;
    logic       carry;
    logic       cin;
    logic [7:0] flag;
  } vec_t;

  vec_t vecs [11];

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: output is only meaningful while eFlag is high.
  logic [8:0] alu_res9;
  always_comb begin
    alu_res9 = '0;
    case (bus.alu_op_flag)
      8'h01: alu_res9 = {1'b0, ~bus.alu_a1};
      8'h02: alu_res9 = {1'b0, bus.alu_a1 | bus.alu_a2};
      8'h04: alu_res9 = {1'b0, bus.alu_a1 & bus.alu_a2};
      8'h08: alu_res9 = {1'b0, bus.alu_a1} + {1'b0, bus.alu_a2} + {8'd0, bus.alu_cin};
      8'h10: alu_res9 = {1'b0, bus.alu_a1} - {1'b0, bus.alu_a2} - {8'd0, bus.alu_cin};
      8'h20: alu_res9 = {1'b0, bus.alu_a1 ^ bus.alu_a2};
      default: alu_res9 = '0;
    endcase
    bus.alu_out  = bus.alu_e_flag ? alu_res9[7:0] : 8'h00;
    bus.alu_cout = bus.alu_e_flag ? alu_res9[8] : 1'b0;
  end

  // Watchdog so a stuck design still ends the run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Reference semantics in plain integer arithmetic.
  function automatic void ref_exec(input int op, input int a, input int b, input int c,
                                   output int res, output int c_out);
    int s;
    res   = 0;
    c_out = c;
    case (op)
      0: res = 255 - a;
      1: res = a | b;
      2: res = a & b;
      5: res = a ^ b;
      3, 6: begin
        s     = a + b + ((op == 6) ? c : 0);
        res   = s % 256;
        c_out = (s > 255) ? 1 : 0;
      end
      default: begin
        s     = a - b - ((op == 7) ? c : 0);
        c_out = (s < 0) ? 1 : 0;
        res   = (s < 0) ? s + 256 : s;
      end
    endcase
  endfunction

  function automatic logic [7:0] ref_flag(input int op);
    case (op)
      0: return 8'h01;
      1: return 8'h02;
      2: return 8'h04;
      3: return 8'h08;
      4: return 8'h10;
      5: return 8'h20;
      6: return 8'h08;
      default: return 8'h10;
    endcase
  endfunction

  // Issue one instruction, follow it through every state, then retire it.
  // Entered and left on a falling edge.
  task automatic apply_stimulus(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs,
                                input logic use_imm, input logic [7:0] imm,
                                input logic [7:0] exp_res, input logic exp_carry,
                                input logic exp_cin, input logic [7:0] exp_flag,
                                input int hold, input logic hold_valid);
    int edges;
    logic [7:0] exp_a2;
    exp_a2 = use_imm ? imm : ref_regs[rs];
    check("in_ready_idle", {31'd0, bus.in_ready}, 32'd1);
    bus.in_op      = op;
    bus.in_rd      = rd;
    bus.in_rs      = rs;
    bus.in_use_imm = use_imm;
    bus.in_imm     = imm;
    bus.in_valid   = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("load_a1", {24'd0, bus.alu_a1}, {24'd0, ref_regs[rd]});
    check("load_a2", {24'd0, bus.alu_a2}, {24'd0, exp_a2});
    check("load_op_flag", {24'd0, bus.alu_op_flag}, {24'd0, exp_flag});
    check("load_cin", {31'd0, bus.alu_cin}, {31'd0, exp_cin});
    check("load_e_flag", {31'd0, bus.alu_e_flag}, 32'd0);
    check("load_in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk);
    #1;
    check("exec_e_flag", {31'd0, bus.alu_e_flag}, 32'd1);
    check("exec_done_valid", {31'd0, bus.done_valid}, 32'd0);
    // Edges counted including the accepting edge.
    edges = 2;
    while (!bus.done_valid && edges < 12) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check("done_latency", edges, 32'd3);
    check("done_e_flag", {31'd0, bus.alu_e_flag}, 32'd0);
    check("done_result", {24'd0, bus.done_result}, {24'd0, exp_res});
    check("done_carry", {31'd0, bus.done_carry}, {31'd0, exp_carry});
    bus.dbg_addr = rd;
    #1;
    check("writeback", {24'd0, bus.dbg_data}, {24'd0, exp_res});
    for (int k = 0; k < hold; k++) begin
      if (hold_valid) begin
        bus.in_op      = 3'd3;
        bus.in_rd      = rd;
        bus.in_use_imm = 1'b1;
        bus.in_imm     = 8'h55;
        bus.in_valid   = 1'b1;
      end
      @(posedge clk);
      #1;
      check("hold_done_valid", {31'd0, bus.done_valid}, 32'd1);
      check("hold_result", {24'd0, bus.done_result}, {24'd0, exp_res});
      check("hold_carry", {31'd0, bus.done_carry}, {31'd0, exp_carry});
      check("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    bus.in_valid   = 1'b0;
    bus.done_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.done_ready = 1'b0;
    check("retire_done_valid", {31'd0, bus.done_valid}, 32'd0);
    check("retire_in_ready", {31'd0, bus.in_ready}, 32'd1);
    ref_regs[rd] = exp_res;
    ref_carry    = exp_carry;
    @(negedge clk);
  endtask

  // Compare every register against the model through the debug port.
  task automatic check_output(input string name);
    for (int i = 0; i < 4; i++) begin
      bus.dbg_addr = i[1:0];
      #1;
      check(name, {24'd0, bus.dbg_data}, {24'd0, ref_regs[i]});
    end
  endtask

  initial begin
    int op, rd, rs, use_imm, imm, a, b, res, c_out, delay;

    checks   = 0;
    failures = 0;
    for (int i = 0; i < 4; i++) ref_regs[i] = 8'h00;
    ref_carry = 1'b0;

    // Directed program; each row's expected values follow from the rows above it.
    vecs[0]  = '{3'd3, 2'd0, 2'd0, 1'b1, 8'd200, 8'd200, 1'b0, 1'b0, 8'h08};
    vecs[1]  = '{3'd3, 2'd0, 2'd0, 1'b1, 8'd100, 8'd44,  1'b1, 1'b0, 8'h08};
    vecs[2]  = '{3'd6, 2'd1, 2'd0, 1'b1, 8'd5,   8'd6,   1'b0, 1'b1, 8'h08};
    vecs[3]  = '{3'd2, 2'd1, 2'd0, 1'b1, 8'd2,   8'd2,   1'b0, 1'b0, 8'h04};
    vecs[4]  = '{3'd1, 2'd2, 2'd0, 1'b1, 8'd5,   8'd5,   1'b0, 1'b0, 8'h02};
    vecs[5]  = '{3'd4, 2'd2, 2'd0, 1'b1, 8'd7,   8'd254, 1'b1, 1'b0, 8'h10};
    vecs[6]  = '{3'd5, 2'd2, 2'd2, 1'b0, 8'd0,   8'd0,   1'b1, 1'b0, 8'h20};
    vecs[7]  = '{3'd0, 2'd1, 2'd3, 1'b0, 8'd0,   8'd253, 1'b1, 1'b0, 8'h01};
    vecs[8]  = '{3'd7, 2'd0, 2'd1, 1'b0, 8'd0,   8'd46,  1'b1, 1'b1, 8'h10};
    vecs[9]  = '{3'd6, 2'd3, 2'd0, 1'b0, 8'd0,   8'd47,  1'b0, 1'b1, 8'h08};
    vecs[10] = '{3'd4, 2'd3, 2'd3, 1'b0, 8'd0,   8'd0,   1'b0, 1'b0, 8'h10};

    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_op      = '0;
    bus.in_rd      = '0;
    bus.in_rs      = '0;
    bus.in_use_imm = 1'b0;
    bus.in_imm     = '0;
    bus.done_ready = 1'b0;
    bus.dbg_addr   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    $display("[TB] reset state");
    check_output("reset_reg");
    check("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("reset_done_valid", {31'd0, bus.done_valid}, 32'd0);
    check("reset_e_flag", {31'd0, bus.alu_e_flag}, 32'd0);
    check("reset_op_flag", {24'd0, bus.alu_op_flag}, 32'd0);
    check("reset_done_result", {24'd0, bus.done_result}, 32'd0);
    check("reset_done_carry", {31'd0, bus.done_carry}, 32'd0);
    @(negedge clk);

    $display("[TB] directed vectors");
    for (int i = 0; i < 11; i++) begin
      apply_stimulus(vecs[i].op, vecs[i].rd, vecs[i].rs, vecs[i].use_imm, vecs[i].imm,
                     vecs[i].res, vecs[i].carry, vecs[i].cin, vecs[i].flag, 0, 1'b0);
    end
    check_output("directed_regs");

    // Back-pressure: result held for five cycles while another instruction waits.
    $display("[TB] done stall");
    apply_stimulus(3'd3, 2'd1, 2'd0, 1'b1, 8'd1, 8'd254, 1'b0, 1'b0, 8'h08, 5, 1'b1);
    check_output("stall_regs");

    // Reset lands while ADD r3,#9 is in EXEC.
    $display("[TB] reset during exec");
    bus.in_op      = 3'd3;
    bus.in_rd      = 2'd3;
    bus.in_rs      = 2'd0;
    bus.in_use_imm = 1'b1;
    bus.in_imm     = 8'd9;
    bus.in_valid   = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("abort_in_exec", {31'd0, bus.alu_e_flag}, 32'd1);
    rst_n = 1'b0;
    #2;
    for (int i = 0; i < 4; i++) ref_regs[i] = 8'h00;
    ref_carry = 1'b0;
    check("abort_e_flag", {31'd0, bus.alu_e_flag}, 32'd0);
    check("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      check("abort_no_done", {31'd0, bus.done_valid}, 32'd0);
    end
    check_output("abort_regs");
    @(negedge clk);

    $display("[TB] random instructions");
    for (int n = 0; n < 40; n++) begin
      op      = int'($urandom_range(0, 7));
      rd      = int'($urandom_range(0, 3));
      rs      = int'($urandom_range(0, 3));
      use_imm = int'($urandom_range(0, 1));
      imm     = int'($urandom_range(0, 255));
      delay   = int'($urandom_range(0, 2));
      a       = int'(ref_regs[rd]);
      b       = (use_imm != 0) ? imm : int'(ref_regs[rs]);
      ref_exec(op, a, b, int'(ref_carry), res, c_out);
      apply_stimulus(op[2:0], rd[1:0], rs[1:0], use_imm[0], imm[7:0], res[7:0], c_out[0],
                     ((op == 6) || (op == 7)) ? ref_carry : 1'b0, ref_flag(op), delay, 1'b0);
    end
    check_output("final_regs");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
